// File: rtl/data_memory_ctrl.sv
// Data memory controller: valid/ready requests, byte/half/word access with extension,
// fault detection, fixed-latency in-order responses and a zero-fill sequence after reset.
module data_memory_ctrl #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        resp_valid,
    output logic [31:0] read_data,
    output logic        fault,
    output logic        busy
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {StInit, StRun} state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_next;

    logic [31:0] r_mem [DEPTH];

    logic        r_pv [LATENCY];
    logic [31:0] r_pd [LATENCY];
    logic        r_pf [LATENCY];

    logic          w_accept;
    logic          w_fault;
    logic          w_oor;
    logic          w_we;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [31:0]   w_shifted;
    logic [31:0]   w_load;
    logic [31:0]   w_resp_data;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;

    assign req_ready = (r_state == StRun);
    assign busy      = (r_state == StInit);

    assign w_accept = req_valid && req_ready && !reset;
    assign w_idx    = address[AW+1:2];
    // Any address bit above the array's byte range set means out of range.
    assign w_oor    = |(address >> (AW + 2));

    always_comb begin
        w_fault = w_oor;
        case (req_size)
            2'b00:   w_fault = w_oor;
            2'b01:   w_fault = w_oor || address[0];
            2'b10:   w_fault = w_oor || (address[1:0] != 2'b00);
            default: w_fault = 1'b1;
        endcase
    end

    assign w_we = w_accept && req_write && !w_fault;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = write_data;
        case (req_size)
            2'b00: begin
                w_be    = 4'b0001 << address[1:0];
                w_wdata = {4{write_data[7:0]}};
            end
            2'b01: begin
                w_be    = address[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{write_data[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = write_data;
            end
        endcase
    end

    assign w_word    = r_mem[w_idx];
    assign w_shifted = w_word >> {address[1:0], 3'b000};

    always_comb begin
        w_load = w_word;
        case (req_size)
            2'b00:   w_load = req_unsigned ? {24'd0, w_shifted[7:0]}
                                           : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load = req_unsigned ? {16'd0, w_shifted[15:0]}
                                           : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_word;
        endcase
    end

    assign w_resp_data = (req_write || w_fault) ? 32'd0 : w_load;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            StInit: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == AW'(DEPTH - 1)) begin
                    w_state_next = StRun;
                end
            end
            StRun:   w_state_next = StRun;
            default: w_state_next = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StInit;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == StInit) begin
                r_mem[r_cnt] <= 32'd0;
            end else if (w_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) begin
                        r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Idle stages carry zeros so the outputs are clean whenever resp_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= 32'd0;
                r_pf[i] <= 1'b0;
            end
        end else begin
            r_pv[0] <= w_accept;
            r_pd[0] <= w_accept ? w_resp_data : 32'd0;
            r_pf[0] <= w_accept && w_fault;
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
                r_pf[i] <= r_pf[i-1];
            end
        end
    end

    assign resp_valid = r_pv[LATENCY-1];
    assign read_data  = r_pd[LATENCY-1];
    assign fault      = r_pf[LATENCY-1];

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: directed and random requests against a byte-array model
// with a queue of expected responses tagged by the cycle they are due.
module tb_data_memory_ctrl;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        fault;
    logic        busy;

    data_memory_ctrl #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .address      (address),
        .write_data   (write_data),
        .resp_valid   (resp_valid),
        .read_data    (read_data),
        .fault        (fault),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        flt;
    } resp_t;

    logic [7:0] mem_b [4*DEPTH];
    resp_t      exp_q [$];
    int         m_fill = DEPTH;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic void model_req(input logic w, input logic [1:0] sz, input logic u,
                                      input logic [31:0] a, input logic [31:0] wd);
        int          n;
        logic        f;
        logic [31:0] val;
        resp_t       r;
        n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        f   = (sz == 2'b11) || ((a % n) != 0) || ((a >> 2) >= DEPTH);
        val = 32'd0;
        if (!f) begin
            if (w) begin
                for (int i = 0; i < n; i++) mem_b[a + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) val[8*i +: 8] = mem_b[a + i];
                if (!u && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
            end
        end
        r.due  = cyc + LAT - 1;
        r.data = val;
        r.flt  = f;
        exp_q.push_back(r);
    endfunction

    task automatic step(input logic rst, input logic v, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] wd);
        logic        exp_v;
        logic [31:0] exp_d;
        logic        exp_f;
        @(negedge clk);
        reset        = rst;
        req_valid    = v;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        address      = a;
        write_data   = wd;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_fill = DEPTH;
            exp_q.delete();
            for (int i = 0; i < 4 * DEPTH; i++) mem_b[i] = 8'd0;
        end else begin
            if (v && m_fill == 0) model_req(w, sz, u, a, wd);
            if (m_fill > 0) m_fill--;
        end
        #1;
        exp_v = 1'b0;
        exp_d = 32'd0;
        exp_f = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_v = 1'b1;
            exp_d = exp_q[0].data;
            exp_f = exp_q[0].flt;
            void'(exp_q.pop_front());
        end
        check_eq("busy", {31'd0, busy}, {31'd0, m_fill > 0});
        check_eq("req_ready", {31'd0, req_ready}, {31'd0, m_fill == 0});
        check_eq("resp_valid", {31'd0, resp_valid}, {31'd0, exp_v});
        check_eq("read_data", read_data, exp_d);
        check_eq("fault", {31'd0, fault}, {31'd0, exp_f});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic ld(input logic [1:0] sz, input logic u, input logic [31:0] a);
        step(1'b0, 1'b1, 1'b0, sz, u, a, 32'hA5A5_A5A5);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        step(1'b0, 1'b1, 1'b1, sz, 1'b0, a, wd);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          sel;

        // Reset, then a request offered during fill that must be ignored.
        step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        ld(2'b10, 1'b0, 32'h10);
        idle(DEPTH);
        ld(2'b10, 1'b0, 32'h3FC);

        st(2'b10, 32'h10, 32'hDEAD_BEEF);
        ld(2'b10, 1'b0, 32'h10);

        st(2'b10, 32'h10, 32'h1122_3344);
        st(2'b00, 32'h13, 32'h0000_0080);
        ld(2'b10, 1'b0, 32'h10);
        ld(2'b00, 1'b0, 32'h13);
        ld(2'b00, 1'b1, 32'h13);
        ld(2'b01, 1'b0, 32'h12);
        ld(2'b01, 1'b1, 32'h12);

        st(2'b10, 32'h04, 32'h0BAD_F00D);
        ld(2'b10, 1'b0, 32'h06);
        st(2'b10, 32'h05, 32'hFFFF_FFFF);
        ld(2'b10, 1'b0, 32'h04);
        ld(2'b11, 1'b0, 32'h08);
        ld(2'b10, 1'b0, 32'h400);
        st(2'b01, 32'h3FF, 32'h1234);
        ld(2'b01, 1'b0, 32'h3FE);

        ld(2'b10, 1'b0, 32'h0);
        ld(2'b10, 1'b0, 32'h4);
        ld(2'b10, 1'b0, 32'h8);
        idle(LAT + 1);

        for (int i = 0; i < 500; i++) begin
            sel = $urandom_range(0, 19);
            sz  = (sel == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (sel == 1)      a = $urandom();
            else if (sel == 2) a = $urandom_range(32'h3F8, 32'h408);
            else               a = $urandom_range(0, 63);
            step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, sz,
                 $urandom_range(0, 1) == 1, a, $urandom());
        end

        // Reset with loads in flight: nothing may emerge, and memory must read back as zero.
        st(2'b10, 32'h20, 32'hCAFE_F00D);
        ld(2'b10, 1'b0, 32'h20);
        ld(2'b10, 1'b0, 32'h10);
        step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        idle(DEPTH);
        ld(2'b10, 1'b0, 32'h20);
        ld(2'b10, 1'b0, 32'h10);
        idle(LAT + 1);

        check_eq("drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised successor to the single-cycle data memory of the monocycle core. It adds a valid/ready request interface, byte/half/word access with sign or zero extension, alignment and range fault detection, a configurable read-latency pipeline, and a hardware zero-fill sequence after reset. It sits between the core's load/store unit and the data array, and also serves as the memory model for the planned pipelined core.

Parameters:
DEPTH, 256, number of 32-bit words; power of two, minimum 4.
LATENCY, 1, cycles from request acceptance to response; legal range 1..4.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
address  input  32  byte address
write_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle response strobe
read_data  output  32  extended load result; 0 for stores and faults
fault  output  1  qualified by resp_valid: request was misaligned, illegal size or out of range
busy  output  1  zero-fill in progress

Behaviour:
- Reset (sampled at a rising edge):
  - outputs: req_ready=0, resp_valid=0, read_data=0, fault=0, busy=1.
  - response pipeline is flushed and the FSM enters INIT with the fill counter at 0.
  - reset asserted in any state, including mid-INIT, restarts INIT from word 0.
- FSM states: INIT and RUN.
  - INIT: writes 0 to word[cnt] each cycle and increments cnt. After the edge that writes word[DEPTH-1], the FSM moves to RUN.
  - INIT lasts exactly DEPTH cycles after reset is released. busy=1 and req_ready=0 throughout INIT.
  - RUN: busy=0 and req_ready=1 every cycle. There is no backpressure and no return to INIT except through reset.
- Acceptance: a request is accepted at an edge where req_valid && req_ready. At most one request is accepted per cycle.
- Word index is address[log2(DEPTH)+1:2]. Byte lane is address[1:0]. Byte order is little-endian.
- Fault conditions, evaluated at acceptance:
  - req_size==11.
  - half access with address[0]=1.
  - word access with address[1:0]!=0.
  - address >= 4*DEPTH.
- A faulted request never modifies memory. Its response has fault=1 and read_data=0.
- Stores:
  - array updated at the accepting edge; only the addressed lanes change.
  - byte store: lane address[1:0] gets write_data[7:0].
  - half store: lanes {address[1],1}:{address[1],0} get write_data[15:0].
  - word store: all 32 bits are written.
- Loads:
  - the array is sampled at the accepting edge, so a load accepted one cycle after a store sees the stored data.
  - the selected lane(s) are shifted to bit 0, then extended per req_unsigned. Word loads are never extended.
- Responses:
  - every accepted request, load or store, produces exactly one response.
  - with acceptance at edge k, resp_valid=1 in the cycle following edge k+LATENCY-1.
  - responses are in order, one cycle wide, with no backpressure.
  - back-to-back requests give back-to-back responses.
  - when resp_valid=0, read_data=0 and fault=0.
- Responses still in flight when reset is asserted are dropped and never emitted.
- req_unsigned is ignored for stores, and write_data is ignored for loads.

Test Plan:
1. Hold reset 2 cycles then release, with DEPTH=256 -> busy stays high for 256 cycles, req_ready rises on the 257th cycle; a word load at 0x3FC then returns 0x00000000 with fault=0.
2. LATENCY=1: store word 0xDEADBEEF at 0x10, then load word at 0x10 next cycle -> resp_valid for the load one cycle after its acceptance, read_data=0xDEADBEEF, fault=0; the store's own response has read_data=0.
3. Word 0x11223344 at 0x10, then byte store 0x80 at 0x13:
   - word load at 0x10 -> 0x80223344.
   - signed byte load at 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080.
   - signed half load at 0x12 -> 0xFFFF8022.
4. Fault cases:
   - word load at 0x06 -> fault=1, read_data=0.
   - word store 0xFFFFFFFF at 0x05 -> fault=1, and word 0x04 is unchanged on reload.
   - req_size=11 -> fault=1.
   - word load at 0x400 with DEPTH=256 -> fault=1.
5. LATENCY=3: word loads at 0x0, 0x4, 0x8 on consecutive cycles -> resp_valid high 3 consecutive cycles, first one in the cycle after the edge 2 cycles past the first acceptance, data in request order.
6. LATENCY=4: two loads in flight, then reset asserted for 1 cycle -> no resp_valid for the rest of the test; busy high for DEPTH cycles; previously written words read back as 0.
